// File: rtl/xsim_run_ctrl.sv
// Run-control sequencer: holds the DUT in reset, counts run cycles, arbitrates finish
// requests, and pulses sim_finish after a drain period. Optional watchdog: XSIM_RUN_CTRL_WATCHDOG_EN.
module xsim_run_ctrl #(
  parameter int RESET_CYCLES   = 20,
  parameter int DRAIN_CYCLES   = 8,
  parameter int NUM_REQ        = 2,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   finish_req,
  input  logic [8*NUM_REQ-1:0] finish_code,
  output logic                 dut_rst_n,
  output logic                 running,
  output logic [CNT_W-1:0]     cycle_count,
  output logic                 finish_valid,
  output logic [2:0]           finish_src,
  output logic [7:0]           exit_code,
  output logic                 sim_finish,
  output logic                 timeout
);

  localparam int HOLD_W  = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {HOLD, RUN, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
  logic                 finish_valid_q, finish_valid_d;
  logic [2:0]           finish_src_q, finish_src_d;
  logic [7:0]           exit_code_q, exit_code_d;
  logic                 sim_finish_q, sim_finish_d;
  logic                 dut_rst_n_q, dut_rst_n_d;
  logic                 running_q, running_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 req_any;
  logic [2:0]           req_idx;
  logic [7:0]           req_code;

`ifdef XSIM_RUN_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_q, timeout_d;
  logic wd_hit;

  assign wd_hit  = (TIMEOUT_CYCLES != 0) && (cycle_count_q >= TIMEOUT_LIM);
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Descending scan so the lowest-index active request is the one left standing.
  always_comb begin
    req_idx  = 3'd0;
    req_code = 8'h00;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (finish_req[i]) begin
        req_idx  = 3'(i);
        req_code = finish_code[8*i +: 8];
      end
    end
  end

  assign req_any = |finish_req;
  assign cnt_inc = (cycle_count_q == {CNT_W{1'b1}}) ? cycle_count_q : cycle_count_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    cycle_count_d  = cycle_count_q;
    finish_valid_d = finish_valid_q;
    finish_src_d   = finish_src_q;
    exit_code_d    = exit_code_q;
    sim_finish_d   = 1'b0;
`ifdef XSIM_RUN_CTRL_WATCHDOG_EN
    timeout_d      = timeout_q;
`endif
    case (state_q)
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cycle_count_d = cnt_inc;
        if (req_any) begin
          finish_src_d   = req_idx;
          exit_code_d    = req_code;
          finish_valid_d = 1'b1;
          drain_cnt_d    = '0;
          state_d        = DRAIN;
        end
`ifdef XSIM_RUN_CTRL_WATCHDOG_EN
        // The watchdog ranks below every real requester.
        else if (wd_hit) begin
          finish_src_d   = 3'(NUM_REQ);
          exit_code_d    = 8'hFF;
          finish_valid_d = 1'b1;
          timeout_d      = 1'b1;
          drain_cnt_d    = '0;
          state_d        = DRAIN;
        end
`endif
      end
      DRAIN: begin
        cycle_count_d = cnt_inc;
        drain_cnt_d   = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DRAIN_LAST) begin
          sim_finish_d = 1'b1;
          state_d      = DONE;
        end
      end
      default: begin
      end
    endcase
    dut_rst_n_d = (state_d != HOLD);
    running_d   = (state_d == RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= HOLD;
      hold_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      cycle_count_q  <= '0;
      finish_valid_q <= 1'b0;
      finish_src_q   <= 3'd0;
      exit_code_q    <= 8'h00;
      sim_finish_q   <= 1'b0;
      dut_rst_n_q    <= 1'b0;
      running_q      <= 1'b0;
`ifdef XSIM_RUN_CTRL_WATCHDOG_EN
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      cycle_count_q  <= cycle_count_d;
      finish_valid_q <= finish_valid_d;
      finish_src_q   <= finish_src_d;
      exit_code_q    <= exit_code_d;
      sim_finish_q   <= sim_finish_d;
      dut_rst_n_q    <= dut_rst_n_d;
      running_q      <= running_d;
`ifdef XSIM_RUN_CTRL_WATCHDOG_EN
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign dut_rst_n    = dut_rst_n_q;
  assign running      = running_q;
  assign cycle_count  = cycle_count_q;
  assign finish_valid = finish_valid_q;
  assign finish_src   = finish_src_q;
  assign exit_code    = exit_code_q;
  assign sim_finish   = sim_finish_q;

endmodule

// File: tb/tb_xsim_run_ctrl.sv
// Scoreboard bench for xsim_run_ctrl: expected finish records are queued by the
// stimulus and popped by a monitor on every sim_finish pulse.
module tb_xsim_run_ctrl;

   typedef struct {
      logic [2:0]  src;
      logic [7:0]  code;
      logic [31:0] count;
      logic        tmo;
   } expFinish_t;

   logic        CLK;
   logic        RST;
   logic [1:0]  finishReq;
   logic [15:0] finishCode;
   logic        dutRstN;
   logic        running;
   logic [31:0] cycleCount;
   logic        finishValid;
   logic [2:0]  finishSrc;
   logic [7:0]  exitCode;
   logic        simFinish;
   logic        timeout;

   expFinish_t  sbQueue[$];
   int          checks = 0;
   int          errors = 0;
   int          edgesSeen;

   xsim_run_ctrl #(
      .RESET_CYCLES(20),
      .DRAIN_CYCLES(8),
      .NUM_REQ(2),
      .CNT_W(32),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .finish_req(finishReq),
      .finish_code(finishCode),
      .dut_rst_n(dutRstN),
      .running(running),
      .cycle_count(cycleCount),
      .finish_valid(finishValid),
      .finish_src(finishSrc),
      .exit_code(exitCode),
      .sim_finish(simFinish),
      .timeout(timeout)
   );

   // Free-running 10-unit clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] req, input logic [15:0] code);
      finishReq  = req;
      finishCode = code;
   endtask

   // Asserts RST for n cycles from a negedge, verifies the reset state, then releases.
   task automatic doReset(input int n);
      RST = 1'b1;
      repeat (n) @(negedge CLK);
      checkOutput("rst_dut_rst_n", {31'd0, dutRstN}, 32'd0);
      checkOutput("rst_running", {31'd0, running}, 32'd0);
      checkOutput("rst_cycle_count", cycleCount, 32'd0);
      checkOutput("rst_finish_valid", {31'd0, finishValid}, 32'd0);
      checkOutput("rst_finish_src", {29'd0, finishSrc}, 32'd0);
      checkOutput("rst_exit_code", {24'd0, exitCode}, 32'd0);
      checkOutput("rst_sim_finish", {31'd0, simFinish}, 32'd0);
      checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);
      RST = 1'b0;
   endtask

   // dut_rst_n must be low through 19 edges and high after the 20th.
   task automatic holdRelease();
      repeat (19) @(negedge CLK);
      checkOutput("hold_dut_rst_n_low", {31'd0, dutRstN}, 32'd0);
      checkOutput("hold_running_low", {31'd0, running}, 32'd0);
      @(negedge CLK);
      checkOutput("hold_dut_rst_n_high", {31'd0, dutRstN}, 32'd1);
      checkOutput("hold_running_high", {31'd1 & 31'd0, running}, 32'd1);
      checkOutput("hold_cycle_count", cycleCount, 32'd0);
   endtask

   // Counts negedges until sim_finish is seen; bounded so a silent DUT cannot hang the run.
   task automatic waitFinish(input int limit, output int n);
      n = 0;
      while (n < limit) begin
         @(negedge CLK);
         n++;
         if (simFinish) break;
      end
      if (!simFinish) begin
         errors++;
         checks++;
         $display("[TB] FAIL wait_sim_finish: no pulse within %0d cycles", limit);
      end
   endtask

   // Monitor: every sim_finish pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (simFinish) begin
         if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_sim_finish: got pulse, expected none at %0t", $time);
         end else begin
            expFinish_t e;
            e = sbQueue.pop_front();
            checkOutput("sb_finish_src", {29'd0, finishSrc}, {29'd0, e.src});
            checkOutput("sb_exit_code", {24'd0, exitCode}, {24'd0, e.code});
            checkOutput("sb_cycle_count", cycleCount, e.count);
            checkOutput("sb_timeout", {31'd0, timeout}, {31'd0, e.tmo});
            checkOutput("sb_finish_valid", {31'd0, finishValid}, 32'd1);
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] stopping");
   end

   initial begin
      RST = 1'b1;
      applyStimulus(2'b00, 16'h0000);
      @(negedge CLK);

      // Test 1/2: single request on the 100th RUN cycle.
      $display("[TB] single request, default hold");
      doReset(3);
      holdRelease();
      repeat (99) @(negedge CLK);
      checkOutput("t2_count_before", cycleCount, 32'd99);
      sbQueue.push_back('{src: 3'd0, code: 8'h05, count: 32'd109, tmo: 1'b0});
      applyStimulus(2'b01, 16'h0005);
      @(negedge CLK);
      applyStimulus(2'b00, 16'h0000);
      checkOutput("t2_running_fall", {31'd0, running}, 32'd0);
      checkOutput("t2_finish_valid", {31'd0, finishValid}, 32'd1);
      checkOutput("t2_finish_src", {29'd0, finishSrc}, 32'd0);
      checkOutput("t2_exit_code", {24'd0, exitCode}, 32'h05);
      checkOutput("t2_count_capture", cycleCount, 32'd100);
      waitFinish(50, edgesSeen);
      checkOutput("t2_drain_latency", edgesSeen, 32'd9);
      repeat (5) @(negedge CLK);
      checkOutput("t2_count_frozen", cycleCount, 32'd109);
      checkOutput("t2_pulse_single", {31'd0, simFinish}, 32'd0);
      checkOutput("t2_dut_rst_n_done", {31'd0, dutRstN}, 32'd1);

      // Test 3: simultaneous requests, lower index wins, later req1 ignored.
      $display("[TB] simultaneous requests");
      doReset(3);
      holdRelease();
      repeat (10) @(negedge CLK);
      sbQueue.push_back('{src: 3'd0, code: 8'h11, count: 32'd20, tmo: 1'b0});
      applyStimulus(2'b11, 16'h2211);
      @(negedge CLK);
      applyStimulus(2'b10, 16'h2211);
      checkOutput("t3_finish_src", {29'd0, finishSrc}, 32'd0);
      checkOutput("t3_exit_code", {24'd0, exitCode}, 32'h11);
      waitFinish(50, edgesSeen);
      checkOutput("t3_drain_latency", edgesSeen, 32'd9);
      repeat (20) @(negedge CLK);
      checkOutput("t3_src_held", {29'd0, finishSrc}, 32'd0);
      checkOutput("t3_code_held", {24'd0, exitCode}, 32'h11);
      applyStimulus(2'b00, 16'h0000);

      // Test 4: request raised during HOLD and held into RUN.
      $display("[TB] request during hold");
      applyStimulus(2'b01, 16'h0033);
      doReset(3);
      sbQueue.push_back('{src: 3'd0, code: 8'h33, count: 32'd10, tmo: 1'b0});
      repeat (20) @(negedge CLK);
      checkOutput("t4_running_first", {31'd0, running}, 32'd1);
      checkOutput("t4_valid_in_hold", {31'd0, finishValid}, 32'd0);
      @(negedge CLK);
      applyStimulus(2'b00, 16'h0000);
      checkOutput("t4_valid_first_run", {31'd0, finishValid}, 32'd1);
      checkOutput("t4_count_first_run", cycleCount, 32'd1);
      waitFinish(50, edgesSeen);
      checkOutput("t4_drain_latency", edgesSeen, 32'd9);

      // Test 5: reset mid-DRAIN suppresses the pulse and restarts the hold.
      $display("[TB] reset during drain");
      doReset(2);
      holdRelease();
      repeat (4) @(negedge CLK);
      applyStimulus(2'b10, 16'h4400);
      @(negedge CLK);
      applyStimulus(2'b00, 16'h0000);
      checkOutput("t5_finish_src", {29'd0, finishSrc}, 32'd1);
      checkOutput("t5_exit_code", {24'd0, exitCode}, 32'h44);
      repeat (3) @(negedge CLK);
      checkOutput("t5_no_pulse_yet", {31'd0, simFinish}, 32'd0);
      doReset(2);
      holdRelease();

      // Test 6: watchdog when enabled, otherwise the run continues indefinitely.
`ifdef XSIM_RUN_CTRL_WATCHDOG_EN
      $display("[TB] watchdog enabled");
      sbQueue.push_back('{src: 3'd2, code: 8'hFF, count: 32'd59, tmo: 1'b1});
      waitFinish(200, edgesSeen);
      checkOutput("t6_watchdog_latency", edgesSeen, 32'd59);
`else
      $display("[TB] watchdog disabled");
      repeat (200) @(negedge CLK);
      checkOutput("t6_still_running", {31'd0, running}, 32'd1);
      checkOutput("t6_timeout_low", {31'd0, timeout}, 32'd0);
      checkOutput("t6_count_200", cycleCount, 32'd200);
`endif

      repeat (5) @(negedge CLK);
      checkOutput("sb_queue_empty", sbQueue.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
